// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and control encodings for the multicycle controller
package mc_pkg;
    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_ALUI,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JUMP,
        C_ILLEGAL
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b110;
    localparam logic [2:0] ALU_R   = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       ext;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic       alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       dmread;
        logic       dmwrite;
        logic       wbsrc;
        logic       jal;
        logic       done;
    } ctrl_t;
endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath bundle (decode inputs and control outputs)
interface mc_if;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    logic       PCwrite;
    logic       IRwrite;
    logic       Ext;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUsrcA;
    logic       ALUsrcB;
    logic [1:0] PCsrc;
    logic [2:0] ALUop;
    logic       DMread;
    logic       DMwrite;
    logic       WBsrc;
    logic       JAL;
    logic       done;
    logic [2:0] state;

    modport master (
        input  zero, op, funct,
        output PCwrite, IRwrite, Ext, RegDst, RegWrite, ALUsrcA, ALUsrcB,
               PCsrc, ALUop, DMread, DMwrite, WBsrc, JAL, done, state
    );

    modport slave (
        output zero, op, funct,
        input  PCwrite, IRwrite, Ext, RegDst, RegWrite, ALUsrcA, ALUsrcB,
               PCsrc, ALUop, DMread, DMwrite, WBsrc, JAL, done, state
    );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode classifier with per-opcode ALU controls
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output class_t     cls_o,
    output logic [2:0] aluop_o,
    output logic       ext_o,
    output logic       alusrca_o,
    output logic       alusrcb_o
);
    // classify the opcode; jr is folded into the jump class so the FSM sees one class per flow
    always_comb begin
        cls_o     = C_ILLEGAL;
        aluop_o   = ALU_ADD;
        ext_o     = 1'b1;
        alusrcb_o = 1'b1;
        alusrca_o = op_i == OP_RTYPE && (funct_i == F_SLL || funct_i == F_SRL || funct_i == F_SRA);
        case (op_i)
            OP_RTYPE: begin
                cls_o     = funct_i == F_JR ? C_JUMP : C_RTYPE;
                aluop_o   = ALU_R;
                alusrcb_o = 1'b0;
            end
            OP_J, OP_JAL: cls_o = C_JUMP;
            OP_BEQ, OP_BNE: begin
                cls_o     = C_BRANCH;
                aluop_o   = ALU_CMP;
                alusrcb_o = 1'b0;
            end
            OP_ADDI, OP_ADDIU: cls_o = C_ALUI;
            OP_SLTI, OP_SLTIU: begin
                cls_o   = C_ALUI;
                aluop_o = ALU_CMP;
            end
            OP_ANDI: begin
                cls_o   = C_ALUI;
                aluop_o = ALU_AND;
                ext_o   = 1'b0;
            end
            OP_ORI: begin
                cls_o   = C_ALUI;
                aluop_o = ALU_OR;
                ext_o   = 1'b0;
            end
            OP_XORI: begin
                cls_o   = C_ALUI;
                aluop_o = ALU_XOR;
                ext_o   = 1'b0;
            end
            OP_LUI: begin
                cls_o   = C_ALUI;
                aluop_o = ALU_LUI;
                ext_o   = 1'b0;
            end
            OP_LW: cls_o = C_LOAD;
            OP_SW: cls_o = C_STORE;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: IF/ID/EXE/MEM/WB sequencer driving a shared MIPS datapath
module multicycle_controller
    import mc_pkg::*;
(
    input logic  clk,
    input logic  rst,
    mc_if.master bus
);
    state_t     state_q, state_d;
    class_t     cls;
    logic [2:0] aluop;
    logic       ext, alusrca, alusrcb;
    ctrl_t      ctrl, ctrl_o;

    mc_decode u_dec (
        .op_i      (bus.op),
        .funct_i   (bus.funct),
        .cls_o     (cls),
        .aluop_o   (aluop),
        .ext_o     (ext),
        .alusrca_o (alusrca),
        .alusrcb_o (alusrcb)
    );

    // state register, the only sequential element
    always_ff @(posedge clk) state_q <= rst ? S_IF : state_d;

    // next state and per-state controls; ALU controls stay stable from EXE through WB
    always_comb begin
        ctrl    = '0;
        state_d = S_IF;
        if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
            ctrl.aluop   = aluop;
            ctrl.ext     = ext;
            ctrl.alusrca = alusrca;
            ctrl.alusrcb = alusrcb;
        end
        case (state_q)
            S_IF: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_SEQ;
                state_d      = S_ID;
            end
            S_ID: begin
                if (cls == C_JUMP) begin
                    ctrl.pcwrite  = 1'b1;
                    ctrl.pcsrc    = bus.op == OP_RTYPE ? PC_JR : PC_JMP;
                    ctrl.jal      = bus.op == OP_JAL;
                    ctrl.regwrite = bus.op == OP_JAL;
                    ctrl.done     = 1'b1;
                end else if (cls == C_ILLEGAL) begin
                    ctrl.done = 1'b1;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls == C_BRANCH) begin
                    ctrl.pcwrite = bus.op == OP_BEQ ? bus.zero : !bus.zero;
                    ctrl.pcsrc   = PC_BR;
                    ctrl.done    = 1'b1;
                end else begin
                    state_d = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (cls == C_LOAD) begin
                    ctrl.dmread = 1'b1;
                    state_d     = S_WB;
                end else begin
                    ctrl.dmwrite = 1'b1;
                    ctrl.done    = 1'b1;
                end
            end
            S_WB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = cls == C_RTYPE;
                ctrl.wbsrc    = cls == C_LOAD;
                ctrl.done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl_o       = rst ? '0 : ctrl;
    assign bus.state    = rst ? 3'b000 : state_q;
    assign bus.PCwrite  = ctrl_o.pcwrite;
    assign bus.IRwrite  = ctrl_o.irwrite;
    assign bus.Ext      = ctrl_o.ext;
    assign bus.RegDst   = ctrl_o.regdst;
    assign bus.RegWrite = ctrl_o.regwrite;
    assign bus.ALUsrcA  = ctrl_o.alusrca;
    assign bus.ALUsrcB  = ctrl_o.alusrcb;
    assign bus.PCsrc    = ctrl_o.pcsrc;
    assign bus.ALUop    = ctrl_o.aluop;
    assign bus.DMread   = ctrl_o.dmread;
    assign bus.DMwrite  = ctrl_o.dmwrite;
    assign bus.WBsrc    = ctrl_o.wbsrc;
    assign bus.JAL      = ctrl_o.jal;
    assign bus.done     = ctrl_o.done;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: instruction-level reference model checked every cycle against the controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {PCwrite,IRwrite,Ext,RegDst,RegWrite,ALUsrcA,ALUsrcB,PCsrc,ALUop,DMread,DMwrite,WBsrc,JAL,done,state}
    wire [19:0] dut_vec = {bus.PCwrite, bus.IRwrite, bus.Ext, bus.RegDst, bus.RegWrite,
                           bus.ALUsrcA, bus.ALUsrcB, bus.PCsrc, bus.ALUop, bus.DMread,
                           bus.DMwrite, bus.WBsrc, bus.JAL, bus.done, bus.state};

    logic [19:0] exp_vec = '0;
    logic        exp_valid = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [19:0] got_q[$];

    localparam int K_R = 0, K_ALUI = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_J = 5, K_JR = 6, K_ILL = 7;

    function automatic int kind(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'd0) return f == 6'd8 ? K_JR : K_R;
        if (o == 6'd2 || o == 6'd3) return K_J;
        if (o == 6'd4 || o == 6'd5) return K_BR;
        if (o >= 6'd8 && o <= 6'd15) return K_ALUI;
        if (o == 6'h23) return K_LW;
        if (o == 6'h2b) return K_SW;
        return K_ILL;
    endfunction

    // cycles per instruction
    function automatic int lat(input int k);
        case (k)
            K_J, K_JR, K_ILL: return 2;
            K_BR:             return 3;
            K_LW:             return 5;
            default:          return 4;
        endcase
    endfunction

    // phase p of an instruction of kind k -> state number (0 IF .. 4 WB)
    function automatic int phase_state(input int k, input int p);
        if (p < 3) return p;
        if (p == 3 && (k == K_LW || k == K_SW)) return 3;
        return 4;
    endfunction

    function automatic logic [19:0] model(input int st, input logic [5:0] o, input logic [5:0] f, input logic z);
        int k;
        logic pcw, irw, ext, rd, rw, sa, sb, dmr, dmw, wbs, jal, dn;
        logic [1:0] pcs;
        logic [2:0] aop;
        k = kind(o, f);
        {pcw, irw, ext, rd, rw, sa, sb, dmr, dmw, wbs, jal, dn} = '0;
        pcs = 2'd0;
        aop = 3'd0;
        if (st >= 2) begin
            ext = !(o >= 6'd12 && o <= 6'd15);
            sb  = !(k == K_R || k == K_BR);
            sa  = k == K_R && (f == 6'd0 || f == 6'd2 || f == 6'd3);
            if (k == K_R) aop = 3'd7;
            else if (k == K_BR || o == 6'd10 || o == 6'd11) aop = 3'd1;
            else if (o == 6'd12) aop = 3'd2;
            else if (o == 6'd13) aop = 3'd3;
            else if (o == 6'd14) aop = 3'd4;
            else if (o == 6'd15) aop = 3'd6;
        end
        case (st)
            0: begin pcw = 1; irw = 1; end
            1: begin
                dn  = k == K_J || k == K_JR || k == K_ILL;
                pcw = k == K_J || k == K_JR;
                pcs = k == K_JR ? 2'd3 : (k == K_J ? 2'd2 : 2'd0);
                jal = o == 6'd3;
                rw  = o == 6'd3;
            end
            2: if (k == K_BR) begin pcw = (o == 6'd4) ? z : !z; pcs = 2'd1; dn = 1; end
            3: begin dmr = k == K_LW; dmw = k == K_SW; dn = k == K_SW; end
            4: begin rw = 1; dn = 1; rd = k == K_R; wbs = k == K_LW; end
            default: ;
        endcase
        return {pcw, irw, ext, rd, rw, sa, sb, pcs, aop, dmr, dmw, wbs, jal, dn, 3'(st)};
    endfunction

    // single compare process: every cycle with a valid expectation
    always @(negedge clk) begin
        if (exp_valid) begin
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL cycle_compare t=%0t op=%h funct=%h zero=%b got=%h want=%h",
                         $time, bus.op, bus.funct, bus.zero, dut_vec, exp_vec);
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // zmode 0/1 forces zero in EXE, 2 randomizes; abort = phase at which rst is raised (-1 none)
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort);
        int k;
        int n;
        k = kind(o, f);
        n = lat(k);
        got_q.delete();
        for (int p = 0; p < n; p++) begin
            @(posedge clk);
            #1;
            if (p == abort) begin
                rst = 1'b1;
                bus.op = 6'($urandom);
                bus.zero = 1'($urandom);
                exp_vec = '0;
                exp_valid = 1'b1;
                @(negedge clk);
                got_q.push_back(dut_vec);
                return;
            end
            rst = 1'b0;
            bus.op    = p == 0 ? 6'($urandom) : o;
            bus.funct = p == 0 ? 6'($urandom) : f;
            bus.zero  = (p == 2 && zmode < 2) ? zmode[0] : 1'($urandom);
            exp_vec   = model(phase_state(k, p), o, f, bus.zero);
            exp_valid = 1'b1;
            @(negedge clk);
            got_q.push_back(dut_vec);
        end
    endtask

    function automatic int done_at();
        foreach (got_q[i]) if (got_q[i][3]) return i;
        return -1;
    endfunction

    logic [5:0] op_tab[19] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                               6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h10, 6'h01};
    logic [5:0] fn_tab[5] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20};

    initial begin
        bus.op = 6'h23;
        bus.funct = 6'h00;
        bus.zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            exp_vec = '0;
            exp_valid = 1'b1;
            @(negedge clk);
        end
        pin("reset_outputs", dut_vec, 20'h00000);

        run_instr(6'h23, 6'h00, 2, -1);
        pin("release_if", got_q[0], 20'hC0000);
        pin("lw_mem", got_q[3], 20'h22083);
        pin("lw_wb", got_q[4], 20'h2A02C);
        pin("lw_done_at", done_at(), 4);

        run_instr(6'h04, 6'h00, 1, -1);
        pin("beq_taken_exe", got_q[2], 20'hA090A);
        run_instr(6'h04, 6'h00, 0, -1);
        pin("beq_not_taken_pcw", got_q[2][19], 1'b0);
        run_instr(6'h05, 6'h00, 0, -1);
        pin("bne_taken_pcw", got_q[2][19], 1'b1);

        run_instr(6'h00, 6'h00, 2, -1);
        pin("sll_exe", got_q[2], 20'h24702);
        pin("sll_wb", got_q[3], 20'h3C70C);
        pin("sll_done_at", done_at(), 3);

        run_instr(6'h00, 6'h08, 2, -1);
        pin("jr_id", got_q[1], 20'h81809);
        run_instr(6'h03, 6'h00, 2, -1);
        pin("jal_id", got_q[1], 20'h89019);
        run_instr(6'h3f, 6'h00, 2, -1);
        pin("illegal_id", got_q[1], 20'h00009);

        run_instr(6'h2b, 6'h00, 2, 2);
        pin("sw_abort_exe", got_q[2], 20'h00000);
        run_instr(6'h08, 6'h00, 2, -1);
        pin("after_abort_if", got_q[0], 20'hC0000);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] o, f;
            o = op_tab[$urandom_range(0, 18)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
            run_instr(o, f, 2, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
        end

        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle replacement for the single-cycle decoder: a finite-state sequencer that drives the shared MIPS datapath (PC, IR, register file, ALU, data memory) over 2–5 cycles per instruction. It decodes `op`/`funct` from the instruction register and the ALU `zero` flag. It asserts each write enable only in the state where that write belongs, so one ALU and one memory port are reused across phases.

## Interface
- No parameters. State encoding and opcodes come from the shared package.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `zero` input 1: ALU zero flag, valid in EXE.
- `op` input 6: IR[31:26], stable from ID onward.
- `funct` input 6: IR[5:0].
- `PCwrite` output 1: PC load enable.
- `IRwrite` output 1: instruction register load enable.
- `Ext` output 1: 1 = sign-extend imm16, 0 = zero-extend.
- `RegDst` output 1: 1 = rd, 0 = rt.
- `RegWrite` output 1: register file write enable.
- `ALUsrcA` output 1: 1 = shamt, 0 = rs.
- `ALUsrcB` output 1: 1 = extended immediate, 0 = rt.
- `PCsrc` output 2: 00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
- `ALUop` output 3: ALU operation code.
- `DMread` output 1: data memory read enable.
- `DMwrite` output 1: data memory write enable.
- `WBsrc` output 1: 1 = memory data, 0 = ALU result.
- `JAL` output 1: selects $31 as destination and PC+4 as write data.
- `done` output 1: high on the last cycle of each instruction.
- `state` output 3: current state, for debug and verification.

## Operation
- States: IF=000, ID=001, EXE=010, MEM=011, WB=100. The state register is the only sequential element; all other outputs are combinational from `state`, `op`, `funct`, and `zero`.
- IF: `IRwrite`=1, `PCwrite`=1, `PCsrc`=00. Next state ID.
- ID:
  - j (000010): `PCwrite`=1, `PCsrc`=10, `done`=1, next IF.
  - jal (000011): the j outputs, plus `JAL`=1 and `RegWrite`=1.
  - jr (op 0, funct 001000): `PCwrite`=1, `PCsrc`=11, `done`=1, next IF.
  - Unsupported opcode: no enables, `done`=1, next IF (treated as NOP).
  - All other instructions: next EXE.
- EXE: ALU controls driven per opcode.
  - beq/bne: `PCwrite` = (`zero`==1 for beq, `zero`==0 for bne), `PCsrc`=01, `done`=1, next IF.
  - lw/sw: next MEM.
  - R-type and ALU-immediate: next WB.
- MEM:
  - lw: `DMread`=1, next WB.
  - sw: `DMwrite`=1, `done`=1, next IF.
- WB: `RegWrite`=1, `done`=1, next IF.
  - R-type: `RegDst`=1, `WBsrc`=0.
  - lw: `RegDst`=0, `WBsrc`=1.
  - Immediate: `RegDst`=0, `WBsrc`=0.
- ALU controls are held through EXE, MEM, and WB:
  - `ALUop`: R 111; addi/addiu/lw/sw 000; andi 010; ori 011; xori 100; lui 110; beq/bne/slti/sltiu 001.
  - `ALUsrcB`=1 for all immediate, load, and store instructions; 0 for R-type and branches.
  - `ALUsrcA`=1 only for R-type sll/srl/sra (funct 000000/000010/000011).
  - `Ext`=0 for andi/ori/xori/lui; 1 otherwise.
- Only ID, EXE, MEM, and WB may assert `RegWrite`/`DMwrite`. Branches and stores never write the register file.

## Timing
- Latency in cycles: j/jal/jr/NOP 2, beq/bne 3, R-type/immediate 4, sw 4, lw 5.
- Reset:
  - When `rst`=1 at a clock edge, `state` becomes IF on that edge.
  - While `rst` is high, every output is forced to 0, including `PCwrite` and `IRwrite`.
  - First fetch happens on the first edge after `rst` deasserts.
- Reset mid-instruction aborts it. Any pending MEM or WB write is dropped, because the state leaves MEM/WB before the next enable cycle.
- `zero` is sampled combinationally in EXE only; it is ignored in every other state.
- `op`/`funct` changing during IF (IR being loaded) must not affect that cycle's outputs, which are fixed for IF.

## Structure
- Package `mc_pkg` holds:
  - state localparams;
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, etc.;
  - funct constants F_JR, F_SLL, F_SRL, F_SRA;
  - ALUop and PCsrc codes.
- One sub-module, `mc_decode`: a combinational opcode classifier. It outputs a 3-bit class (RTYPE, ALUI, LOAD, STORE, BRANCH, JUMP, ILLEGAL) plus the per-opcode `ALUop`/`Ext`/`ALUsrcA`/`ALUsrcB`.
- The top-level FSM uses only the class for transitions.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with op=100011 → all outputs 0, `state`=000. Release → IF (`IRwrite`=1, `PCwrite`=1) next cycle.
- lw (op 100011) → states IF, ID, EXE, MEM, WB. `DMread`=1 only in MEM; `RegWrite`=1, `WBsrc`=1, `RegDst`=0, `done`=1 only in WB; `ALUop`=000, `ALUsrcB`=1.
- beq (op 000100) with `zero`=1 → `PCwrite`=1, `PCsrc`=01 in EXE, then back to IF. With `zero`=0 → `PCwrite`=0. bne with `zero`=0 → `PCwrite`=1. `RegWrite` stays 0 throughout.
- R-type sll (op 0, funct 000000) → 4 cycles, `ALUsrcA`=1, `ALUop`=111, WB has `RegDst`=1. jr (funct 001000) → 2 cycles, `PCsrc`=11 in ID, no `RegWrite`.
- jal (op 000011) → ID asserts `JAL`=1, `RegWrite`=1, `PCwrite`=1, `PCsrc`=10, `done`=1. Illegal op 111111 → 2 cycles, all enables 0.
- sw (op 101011) with `rst` asserted during EXE → next state IF, `DMwrite` never asserted.
